scoreboard_mp: RTL and testbench
================================

Name: scoreboard_mp

Overview:
Parametrised in-order-commit scoreboard for the issue/execute/commit path: a circular buffer of NR_ENTRIES in-flight instructions with NR_WB_PORTS out-of-order writeback ports, one in-order commit port, flush, and NR_LOOKUP register-busy/forwarding lookups. It sits between issue (allocates entries, receives transaction IDs) and the functional units (write back by transaction ID). Commit drains entries to the register file and exception logic.

Parameters:
NR_ENTRIES, 8, number of scoreboard entries; power of two, at least 2
NR_WB_PORTS, 2, number of independent writeback ports
NR_LOOKUP, 2, number of source-register lookup ports
CTRL_W, 12, opaque control payload width (fu + op), carried issue -> commit unmodified
TID_W, $clog2(NR_ENTRIES), transaction ID width (derived, not overridable)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
flush_i  in  1  discard all in-flight entries
issue_valid_i  in  1  issue request
issue_ready_o  out  1  entry available (count < NR_ENTRIES)
issue_ctrl_i  in  CTRL_W  control payload
issue_rd_i  in  5  destination register
issue_imm_i  in  64  initial result field (immediate)
issue_ex_valid_i  in  1  exception already raised at issue
issue_ex_cause_i  in  64  exception cause
issue_trans_id_o  out  TID_W  ID the next accepted issue receives (tail pointer)
wb_valid_i  in  NR_WB_PORTS  per-port writeback strobe
wb_trans_id_i  in  NR_WB_PORTS*TID_W  per-port target entry
wb_result_i  in  NR_WB_PORTS*64  per-port result
wb_ex_valid_i  in  NR_WB_PORTS  per-port exception flag
wb_ex_cause_i  in  NR_WB_PORTS*64  per-port cause
commit_valid_o  out  1  head entry occupied and finished
commit_ack_i  in  1  commit stage consumes head
commit_trans_id_o  out  TID_W  head index
commit_ctrl_o  out  CTRL_W  head control payload
commit_rd_o  out  5  head destination
commit_result_o  out  64  head result
commit_ex_valid_o  out  1  head exception flag
commit_ex_cause_o  out  64  head exception cause
lookup_rs_i  in  NR_LOOKUP*5  source registers to check
lookup_busy_o  out  NR_LOOKUP  an in-flight entry writes this register
lookup_ready_o  out  NR_LOOKUP  youngest such producer finished without exception
lookup_value_o  out  NR_LOOKUP*64  youngest producer's result (forwarding)

Behaviour:
- State: per-entry {occupied, done, ctrl, rd, result, ex_valid, ex_cause}; head, tail (TID_W bits, natural wrap NR_ENTRIES-1 -> 0); count (TID_W+1 bits, 0..NR_ENTRIES).
- Reset (rst_i sampled on edge) and flush_i: all occupied/done cleared, head=tail=count=0; takes priority over issue, writeback and commit in the same cycle. After reset: issue_ready_o=1, issue_trans_id_o=0, commit_valid_o=0, lookup_busy_o=0, all data outputs 0.
- Issue: accepted when issue_valid_i && issue_ready_o; entry[tail] <= {occupied=1, done=issue_ex_valid_i, ctrl, rd, result=imm, ex}; tail+1. issue_ready_o depends on registered count only: when full, no issue is accepted even if commit pops in that cycle.
- Writeback: for each port p with wb_valid_i[p] and entry[trans_id] occupied: result, ex_valid, ex_cause written; done=1. Writeback to an unoccupied entry is ignored. Several ports targeting the same entry in one cycle: highest port index wins. Writeback to an already-done entry overwrites it.
- Commit: commit_* driven combinationally from entry[head]; commit_valid_o = occupied[head] && done[head]. On commit_valid_o && commit_ack_i: entry cleared, head+1. commit_ack_i without commit_valid_o is ignored. Latency issue -> commit_valid_o (ex at issue) = 1 cycle; writeback -> commit_valid_o = 1 cycle.
- count: +1 on issue only, -1 on commit only, unchanged on both or neither.
- Lookup (combinational, registered state only, no same-cycle wb bypass): rs==0 never busy. Otherwise busy=1 if any occupied entry has rd==rs; the youngest match (closest behind tail, wrap-aware age order from head) drives ready=done&&!ex_valid and value=result. If not busy: ready=0, value=0.

Test Plan:
- Reset, then issue 8 entries (rd=1..8) with no wb -> issue_ready_o=0 after the 8th, count full, issue_trans_id_o=0 (wrapped), commit_valid_o=0.
- Issue IDs 0,1,2; wb port1 writes ID2 result=0xC, then port0 writes ID0=0xA -> commit_valid_o only after ID0's wb (ID0 result 0xA); ID1 blocks ID2 until ID1 is written back.
- Issue rd=5 twice (IDs 3,4); wb ID3=0x11 -> lookup rs=5 busy=1, ready=0 (ID4 youngest); wb ID4=0x22 -> ready=1, value=0x22; lookup rs=0 -> busy=0.
- Same cycle: port0 and port1 both target ID1 with 0x1 and 0x2 -> commit_result_o=0x2; wb to an unoccupied ID -> no state change.
- Full buffer, issue_valid_i=1 and commit ack in the same cycle -> one pop, no push, count=7; next cycle issue accepted at old head index.
- Flush with 5 in flight plus simultaneous issue, wb and ack -> next cycle count=0, head=tail=0, commit_valid_o=0, all lookup_busy_o=0.

Source files
------------

// File: rtl/scoreboard_mp.sv
// In-order-commit scoreboard: circular buffer of in-flight instructions with
// out-of-order writeback by transaction ID, one commit port, flush and register lookups.
module scoreboard_mp #(
  parameter int NR_ENTRIES  = 8,
  parameter int NR_WB_PORTS = 2,
  parameter int NR_LOOKUP   = 2,
  parameter int CTRL_W      = 12,
  localparam int TID_W      = $clog2(NR_ENTRIES)
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        flush_i,
  input  logic                        issue_valid_i,
  output logic                        issue_ready_o,
  input  logic [CTRL_W-1:0]           issue_ctrl_i,
  input  logic [4:0]                  issue_rd_i,
  input  logic [63:0]                 issue_imm_i,
  input  logic                        issue_ex_valid_i,
  input  logic [63:0]                 issue_ex_cause_i,
  output logic [TID_W-1:0]            issue_trans_id_o,
  input  logic [NR_WB_PORTS-1:0]      wb_valid_i,
  input  logic [NR_WB_PORTS*TID_W-1:0] wb_trans_id_i,
  input  logic [NR_WB_PORTS*64-1:0]   wb_result_i,
  input  logic [NR_WB_PORTS-1:0]      wb_ex_valid_i,
  input  logic [NR_WB_PORTS*64-1:0]   wb_ex_cause_i,
  output logic                        commit_valid_o,
  input  logic                        commit_ack_i,
  output logic [TID_W-1:0]            commit_trans_id_o,
  output logic [CTRL_W-1:0]           commit_ctrl_o,
  output logic [4:0]                  commit_rd_o,
  output logic [63:0]                 commit_result_o,
  output logic                        commit_ex_valid_o,
  output logic [63:0]                 commit_ex_cause_o,
  input  logic [NR_LOOKUP*5-1:0]      lookup_rs_i,
  output logic [NR_LOOKUP-1:0]        lookup_busy_o,
  output logic [NR_LOOKUP-1:0]        lookup_ready_o,
  output logic [NR_LOOKUP*64-1:0]     lookup_value_o
);

  localparam logic [TID_W:0] CNT_FULL = (TID_W+1)'(NR_ENTRIES);

  logic [NR_ENTRIES-1:0] occ_q, occ_d, done_q, done_d, exv_q, exv_d;
  logic [CTRL_W-1:0]     ctrl_q  [NR_ENTRIES];
  logic [CTRL_W-1:0]     ctrl_d  [NR_ENTRIES];
  logic [4:0]            rd_q    [NR_ENTRIES];
  logic [4:0]            rd_d    [NR_ENTRIES];
  logic [63:0]           res_q   [NR_ENTRIES];
  logic [63:0]           res_d   [NR_ENTRIES];
  logic [63:0]           cause_q [NR_ENTRIES];
  logic [63:0]           cause_d [NR_ENTRIES];
  logic [TID_W-1:0]      head_q, head_d, tail_q, tail_d;
  logic [TID_W:0]        count_q, count_d;

  logic                  issue_fire, commit_fire;
  logic [TID_W-1:0]      wb_tid  [NR_WB_PORTS];
  logic [TID_W-1:0]      age_idx [NR_ENTRIES];

  for (genvar p = 0; p < NR_WB_PORTS; p++) begin : g_wb_tid
    assign wb_tid[p] = wb_trans_id_i[p*TID_W +: TID_W];
  end

  // age_idx[0] is the oldest slot (head); higher indices are younger
  for (genvar a = 0; a < NR_ENTRIES; a++) begin : g_age
    assign age_idx[a] = head_q + TID_W'(a);
  end

  assign issue_ready_o    = (count_q < CNT_FULL);
  assign issue_trans_id_o = tail_q;
  assign issue_fire       = issue_valid_i && issue_ready_o;

  assign commit_valid_o    = occ_q[head_q] && done_q[head_q];
  assign commit_trans_id_o = head_q;
  assign commit_ctrl_o     = ctrl_q[head_q];
  assign commit_rd_o       = rd_q[head_q];
  assign commit_result_o   = res_q[head_q];
  assign commit_ex_valid_o = exv_q[head_q];
  assign commit_ex_cause_o = cause_q[head_q];
  assign commit_fire       = commit_valid_o && commit_ack_i;

  always_comb begin
    occ_d   = occ_q;
    done_d  = done_q;
    exv_d   = exv_q;
    ctrl_d  = ctrl_q;
    rd_d    = rd_q;
    res_d   = res_q;
    cause_d = cause_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;

    // The tail slot is never occupied when issue fires, so issue and
    // writeback can never target the same entry in one cycle.
    if (issue_fire) begin
      occ_d[tail_q]   = 1'b1;
      done_d[tail_q]  = issue_ex_valid_i;
      exv_d[tail_q]   = issue_ex_valid_i;
      ctrl_d[tail_q]  = issue_ctrl_i;
      rd_d[tail_q]    = issue_rd_i;
      res_d[tail_q]   = issue_imm_i;
      cause_d[tail_q] = issue_ex_cause_i;
      tail_d          = tail_q + 1'b1;
    end

    for (int p = 0; p < NR_WB_PORTS; p++) begin
      if (wb_valid_i[p] && occ_q[wb_tid[p]]) begin
        done_d[wb_tid[p]]  = 1'b1;
        exv_d[wb_tid[p]]   = wb_ex_valid_i[p];
        res_d[wb_tid[p]]   = wb_result_i[p*64 +: 64];
        cause_d[wb_tid[p]] = wb_ex_cause_i[p*64 +: 64];
      end
    end

    if (commit_fire) begin
      occ_d[head_q]   = 1'b0;
      done_d[head_q]  = 1'b0;
      exv_d[head_q]   = 1'b0;
      ctrl_d[head_q]  = '0;
      rd_d[head_q]    = '0;
      res_d[head_q]   = '0;
      cause_d[head_q] = '0;
      head_d          = head_q + 1'b1;
    end

    case ({issue_fire, commit_fire})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if (flush_i) begin
      occ_d   = '0;
      done_d  = '0;
      exv_d   = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      for (int e = 0; e < NR_ENTRIES; e++) begin
        ctrl_d[e]  = '0;
        rd_d[e]    = '0;
        res_d[e]   = '0;
        cause_d[e] = '0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      occ_q   <= '0;
      done_q  <= '0;
      exv_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int e = 0; e < NR_ENTRIES; e++) begin
        ctrl_q[e]  <= '0;
        rd_q[e]    <= '0;
        res_q[e]   <= '0;
        cause_q[e] <= '0;
      end
    end else begin
      occ_q   <= occ_d;
      done_q  <= done_d;
      exv_q   <= exv_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      ctrl_q  <= ctrl_d;
      rd_q    <= rd_d;
      res_q   <= res_d;
      cause_q <= cause_d;
    end
  end

  // Walk oldest to youngest so the last match is the youngest producer.
  always_comb begin
    lookup_busy_o  = '0;
    lookup_ready_o = '0;
    lookup_value_o = '0;
    for (int l = 0; l < NR_LOOKUP; l++) begin
      for (int i = 0; i < NR_ENTRIES; i++) begin
        if ((lookup_rs_i[l*5 +: 5] != 5'd0) && occ_q[age_idx[i]] &&
            (rd_q[age_idx[i]] == lookup_rs_i[l*5 +: 5])) begin
          lookup_busy_o[l]          = 1'b1;
          lookup_ready_o[l]         = done_q[age_idx[i]] && !exv_q[age_idx[i]];
          lookup_value_o[l*64 +: 64] = res_q[age_idx[i]];
        end
      end
    end
  end

endmodule

// File: tb/tb_scoreboard_mp.sv
// Directed bench for scoreboard_mp: each task drives one scenario and checks
// outputs against hand-computed values, sampling 1 time unit after the clock edge.
module tb_scoreboard_mp;
  localparam int NE = 8, NW = 2, NL = 2, CW = 12, TW = 3;

  logic            clk = 1'b0;
  logic            rst, flush, issue_valid, issue_ready, issue_ex_valid;
  logic [CW-1:0]   issue_ctrl;
  logic [4:0]      issue_rd;
  logic [63:0]     issue_imm, issue_ex_cause;
  logic [TW-1:0]   issue_trans_id;
  logic [NW-1:0]   wb_valid, wb_ex_valid;
  logic [NW*TW-1:0] wb_trans_id;
  logic [NW*64-1:0] wb_result, wb_ex_cause;
  logic            commit_valid, commit_ack, commit_ex_valid;
  logic [TW-1:0]   commit_trans_id;
  logic [CW-1:0]   commit_ctrl;
  logic [4:0]      commit_rd;
  logic [63:0]     commit_result, commit_ex_cause;
  logic [NL*5-1:0] lookup_rs;
  logic [NL-1:0]   lookup_busy, lookup_ready;
  logic [NL*64-1:0] lookup_value;

  int errors = 0;
  int checks = 0;

  scoreboard_mp #(.NR_ENTRIES(NE), .NR_WB_PORTS(NW), .NR_LOOKUP(NL), .CTRL_W(CW)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .issue_valid_i(issue_valid), .issue_ready_o(issue_ready), .issue_ctrl_i(issue_ctrl),
    .issue_rd_i(issue_rd), .issue_imm_i(issue_imm), .issue_ex_valid_i(issue_ex_valid),
    .issue_ex_cause_i(issue_ex_cause), .issue_trans_id_o(issue_trans_id),
    .wb_valid_i(wb_valid), .wb_trans_id_i(wb_trans_id), .wb_result_i(wb_result),
    .wb_ex_valid_i(wb_ex_valid), .wb_ex_cause_i(wb_ex_cause),
    .commit_valid_o(commit_valid), .commit_ack_i(commit_ack), .commit_trans_id_o(commit_trans_id),
    .commit_ctrl_o(commit_ctrl), .commit_rd_o(commit_rd), .commit_result_o(commit_result),
    .commit_ex_valid_o(commit_ex_valid), .commit_ex_cause_o(commit_ex_cause),
    .lookup_rs_i(lookup_rs), .lookup_busy_o(lookup_busy), .lookup_ready_o(lookup_ready),
    .lookup_value_o(lookup_value)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    flush = 0; issue_valid = 0; issue_ex_valid = 0; issue_ctrl = '0; issue_rd = '0;
    issue_imm = '0; issue_ex_cause = '0; wb_valid = '0; wb_ex_valid = '0;
    wb_trans_id = '0; wb_result = '0; wb_ex_cause = '0; commit_ack = 0;
  endtask

  task automatic do_reset();
    clear_in();
    rst = 1; tick(); tick(); rst = 0; #1;
  endtask

  task automatic do_issue(input logic [4:0] rd, input logic [63:0] imm, input logic ex,
                          input logic [63:0] cause);
    issue_valid = 1; issue_rd = rd; issue_imm = imm; issue_ex_valid = ex;
    issue_ex_cause = cause; issue_ctrl = CW'({rd, 3'b101});
    tick(); clear_in(); #1;
  endtask

  task automatic do_wb(input int port, input logic [TW-1:0] id, input logic [63:0] res);
    wb_valid[port] = 1'b1; wb_trans_id[port*TW +: TW] = id; wb_result[port*64 +: 64] = res;
    tick(); clear_in(); #1;
  endtask

  task automatic do_ack();
    commit_ack = 1; tick(); clear_in(); #1;
  endtask

  task automatic test_reset();
    lookup_rs = {5'd2, 5'd1};
    do_reset();
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%0b exp=1", issue_ready); end
    checks++; if (issue_trans_id !== 3'd0) begin errors++; $display("FAIL reset_tid got=%0d exp=0", issue_trans_id); end
    checks++; if (commit_valid !== 1'b0) begin errors++; $display("FAIL reset_cvalid got=%0b exp=0", commit_valid); end
    checks++; if (lookup_busy !== 2'b00) begin errors++; $display("FAIL reset_busy got=%0b exp=0", lookup_busy); end
    checks++; if (commit_result !== 64'd0 || commit_rd !== 5'd0) begin errors++; $display("FAIL reset_data got=%0h/%0d exp=0/0", commit_result, commit_rd); end
  endtask

  task automatic test_fill();
    do_reset();
    for (int i = 1; i <= 8; i++) do_issue(5'(i), 64'(i * 16), 1'b0, 64'd0);
    checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL fill_ready got=%0b exp=0", issue_ready); end
    checks++; if (issue_trans_id !== 3'd0) begin errors++; $display("FAIL fill_tid_wrap got=%0d exp=0", issue_trans_id); end
    checks++; if (dut.count_q !== 4'd8) begin errors++; $display("FAIL fill_count got=%0d exp=8", dut.count_q); end
    checks++; if (commit_valid !== 1'b0) begin errors++; $display("FAIL fill_cvalid got=%0b exp=0", commit_valid); end
    do_issue(5'd30, 64'h99, 1'b1, 64'd0);
    checks++; if (dut.count_q !== 4'd8 || issue_trans_id !== 3'd0) begin errors++; $display("FAIL full_reject got=%0d/%0d exp=8/0", dut.count_q, issue_trans_id); end
    lookup_rs = {5'd0, 5'd3}; #1;
    checks++; if (lookup_busy[0] !== 1'b1 || lookup_ready[0] !== 1'b0 || lookup_value[63:0] !== 64'h30) begin errors++; $display("FAIL fill_lookup got=%0b/%0b/%0h exp=1/0/30", lookup_busy[0], lookup_ready[0], lookup_value[63:0]); end
  endtask

  task automatic test_ooo_wb();
    do_reset();
    do_issue(5'd1, 64'd0, 1'b0, 64'd0);
    do_issue(5'd2, 64'd0, 1'b0, 64'd0);
    do_issue(5'd3, 64'd0, 1'b0, 64'd0);
    do_wb(1, 3'd2, 64'hC);
    checks++; if (commit_valid !== 1'b0) begin errors++; $display("FAIL ooo_wait_id0 got=%0b exp=0", commit_valid); end
    do_wb(0, 3'd0, 64'hA);
    checks++; if (commit_valid !== 1'b1 || commit_result !== 64'hA || commit_trans_id !== 3'd0 || commit_rd !== 5'd1) begin errors++; $display("FAIL ooo_id0 got=%0b/%0h/%0d/%0d exp=1/a/0/1", commit_valid, commit_result, commit_trans_id, commit_rd); end
    checks++; if (commit_ctrl !== 12'({5'd1, 3'b101})) begin errors++; $display("FAIL ooo_ctrl got=%0h exp=%0h", commit_ctrl, 12'({5'd1, 3'b101})); end
    do_ack();
    checks++; if (commit_valid !== 1'b0 || commit_trans_id !== 3'd1) begin errors++; $display("FAIL ooo_id1_blocks got=%0b/%0d exp=0/1", commit_valid, commit_trans_id); end
    do_wb(0, 3'd1, 64'hB);
    checks++; if (commit_valid !== 1'b1 || commit_result !== 64'hB) begin errors++; $display("FAIL ooo_id1 got=%0b/%0h exp=1/b", commit_valid, commit_result); end
    do_ack();
    checks++; if (commit_valid !== 1'b1 || commit_result !== 64'hC || commit_trans_id !== 3'd2) begin errors++; $display("FAIL ooo_id2 got=%0b/%0h/%0d exp=1/c/2", commit_valid, commit_result, commit_trans_id); end
    do_ack();
    checks++; if (commit_valid !== 1'b0 || dut.count_q !== 4'd0 || issue_trans_id !== 3'd3) begin errors++; $display("FAIL ooo_drain got=%0b/%0d/%0d exp=0/0/3", commit_valid, dut.count_q, issue_trans_id); end
  endtask

  task automatic test_lookup();
    do_issue(5'd5, 64'h99, 1'b0, 64'd0);
    do_issue(5'd5, 64'h77, 1'b0, 64'd0);
    lookup_rs = {5'd0, 5'd5}; #1;
    checks++; if (lookup_busy[0] !== 1'b1 || lookup_ready[0] !== 1'b0 || lookup_value[63:0] !== 64'h77) begin errors++; $display("FAIL lk_issued got=%0b/%0b/%0h exp=1/0/77", lookup_busy[0], lookup_ready[0], lookup_value[63:0]); end
    do_wb(0, 3'd3, 64'h11);
    checks++; if (lookup_busy[0] !== 1'b1 || lookup_ready[0] !== 1'b0 || lookup_value[63:0] !== 64'h77) begin errors++; $display("FAIL lk_older_done got=%0b/%0b/%0h exp=1/0/77", lookup_busy[0], lookup_ready[0], lookup_value[63:0]); end
    do_wb(1, 3'd4, 64'h22);
    checks++; if (lookup_ready[0] !== 1'b1 || lookup_value[63:0] !== 64'h22) begin errors++; $display("FAIL lk_young_done got=%0b/%0h exp=1/22", lookup_ready[0], lookup_value[63:0]); end
    checks++; if (lookup_busy[1] !== 1'b0 || lookup_ready[1] !== 1'b0 || lookup_value[127:64] !== 64'd0) begin errors++; $display("FAIL lk_rs0 got=%0b/%0b/%0h exp=0/0/0", lookup_busy[1], lookup_ready[1], lookup_value[127:64]); end
    do_ack();
    checks++; if (commit_valid !== 1'b1 || commit_trans_id !== 3'd4 || commit_result !== 64'h22) begin errors++; $display("FAIL lk_commit4 got=%0b/%0d/%0h exp=1/4/22", commit_valid, commit_trans_id, commit_result); end
    do_ack();
    checks++; if (lookup_busy[0] !== 1'b0 || commit_valid !== 1'b0) begin errors++; $display("FAIL lk_drained got=%0b/%0b exp=0/0", lookup_busy[0], commit_valid); end
  endtask

  task automatic test_same_cycle_wb();
    do_reset();
    do_issue(5'd7, 64'd0, 1'b0, 64'd0);
    do_issue(5'd8, 64'd0, 1'b0, 64'd0);
    wb_valid = 2'b11; wb_trans_id = {3'd1, 3'd1}; wb_result = {64'h2, 64'h1};
    tick(); clear_in(); #1;
    checks++; if (commit_valid !== 1'b0) begin errors++; $display("FAIL same_head_wait got=%0b exp=0", commit_valid); end
    wb_valid = 2'b11; wb_trans_id = {3'd5, 3'd0}; wb_result = {64'hDEAD, 64'h3};
    tick(); clear_in(); #1;
    checks++; if (commit_valid !== 1'b1 || commit_result !== 64'h3) begin errors++; $display("FAIL same_id0 got=%0b/%0h exp=1/3", commit_valid, commit_result); end
    checks++; if (dut.occ_q[5] !== 1'b0 || dut.done_q[5] !== 1'b0 || dut.res_q[5] !== 64'd0) begin errors++; $display("FAIL wb_unoccupied got=%0b/%0b/%0h exp=0/0/0", dut.occ_q[5], dut.done_q[5], dut.res_q[5]); end
    do_ack();
    checks++; if (commit_valid !== 1'b1 || commit_trans_id !== 3'd1 || commit_result !== 64'h2) begin errors++; $display("FAIL same_highport got=%0b/%0d/%0h exp=1/1/2", commit_valid, commit_trans_id, commit_result); end
    do_ack();
    do_issue(5'd9, 64'h44, 1'b1, 64'h5);
    lookup_rs = {5'd0, 5'd9}; #1;
    checks++; if (commit_valid !== 1'b1 || commit_ex_valid !== 1'b1 || commit_ex_cause !== 64'h5 || commit_result !== 64'h44 || commit_trans_id !== 3'd2) begin errors++; $display("FAIL ex_issue got=%0b/%0b/%0h/%0h/%0d exp=1/1/5/44/2", commit_valid, commit_ex_valid, commit_ex_cause, commit_result, commit_trans_id); end
    checks++; if (lookup_busy[0] !== 1'b1 || lookup_ready[0] !== 1'b0) begin errors++; $display("FAIL ex_lookup got=%0b/%0b exp=1/0", lookup_busy[0], lookup_ready[0]); end
    do_ack();
  endtask

  task automatic test_full_issue_commit();
    do_reset();
    for (int i = 1; i <= 8; i++) do_issue(5'(i), 64'(i), 1'b1, 64'd0);
    issue_valid = 1; issue_rd = 5'd20; issue_imm = 64'h55; issue_ex_valid = 1; commit_ack = 1;
    tick(); clear_in(); #1;
    checks++; if (dut.count_q !== 4'd7 || issue_ready !== 1'b1) begin errors++; $display("FAIL full_pop_only got=%0d/%0b exp=7/1", dut.count_q, issue_ready); end
    checks++; if (commit_trans_id !== 3'd1 || issue_trans_id !== 3'd0) begin errors++; $display("FAIL full_ptrs got=%0d/%0d exp=1/0", commit_trans_id, issue_trans_id); end
    do_issue(5'd20, 64'h55, 1'b1, 64'd0);
    lookup_rs = {5'd20, 5'd1}; #1;
    checks++; if (issue_trans_id !== 3'd1 || dut.count_q !== 4'd8 || issue_ready !== 1'b0) begin errors++; $display("FAIL full_reissue got=%0d/%0d/%0b exp=1/8/0", issue_trans_id, dut.count_q, issue_ready); end
    checks++; if (lookup_busy !== 2'b10) begin errors++; $display("FAIL full_lookup got=%0b exp=10", lookup_busy); end
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 1; i <= 5; i++) do_issue(5'(i), 64'd0, 1'b0, 64'd0);
    do_wb(0, 3'd0, 64'hAA);
    lookup_rs = {5'd2, 5'd1};
    flush = 1; issue_valid = 1; issue_rd = 5'd6; commit_ack = 1;
    wb_valid = 2'b10; wb_trans_id = {3'd1, 3'd0}; wb_result = {64'hBB, 64'd0};
    tick(); clear_in(); #1;
    checks++; if (dut.count_q !== 4'd0 || issue_trans_id !== 3'd0 || commit_trans_id !== 3'd0) begin errors++; $display("FAIL flush_ptrs got=%0d/%0d/%0d exp=0/0/0", dut.count_q, issue_trans_id, commit_trans_id); end
    checks++; if (commit_valid !== 1'b0 || lookup_busy !== 2'b00 || issue_ready !== 1'b1) begin errors++; $display("FAIL flush_state got=%0b/%0b/%0b exp=0/00/1", commit_valid, lookup_busy, issue_ready); end
    do_issue(5'd1, 64'h10, 1'b0, 64'd0);
    checks++; if (issue_trans_id !== 3'd1 || commit_valid !== 1'b0 || lookup_busy !== 2'b01 || lookup_value[63:0] !== 64'h10) begin errors++; $display("FAIL flush_reuse got=%0d/%0b/%0b/%0h exp=1/0/01/10", issue_trans_id, commit_valid, lookup_busy, lookup_value[63:0]); end
  endtask

  initial begin
    clear_in();
    rst = 1;
    lookup_rs = '0;
    test_reset();
    test_fill();
    test_ooo_wb();
    test_lookup();
    test_same_cycle_wb();
    test_full_issue_commit();
    test_flush();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
